// File: rtl/tile_render_ctrl.sv
// tile_render_ctrl: per-pixel scheduler for the tile background layer.
// Turns DrawX/DrawY plus a per-frame scroll into a tile-map read, a tile-pixel
// ROM read and a palette lookup. RGB is registered with a fixed 4-cycle latency
// at one pixel per clock.
module tile_render_ctrl #(
    parameter int TILE_W     = 16,
    parameter int TILE_H     = 16,
    parameter int MAP_COLS   = 40,
    parameter int MAP_ROWS   = 30,
    parameter int TILE_ID_W  = 4,
    parameter int PIX_IDX_W  = 5,
    parameter int TRANSP_IDX = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    input  logic                 pix_valid_in,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [9:0]           scroll_x,
    input  logic [9:0]           scroll_y,
    input  logic [11:0]          bg_rgb,
    output logic [10:0]          map_addr,
    input  logic [TILE_ID_W-1:0] map_data,
    output logic [TILE_ID_W+$clog2(TILE_H)+$clog2(TILE_W)-1:0] rom_addr,
    input  logic [PIX_IDX_W-1:0] rom_data,
    output logic [PIX_IDX_W-1:0] pal_index,
    input  logic [3:0]           pal_red,
    input  logic [3:0]           pal_green,
    input  logic [3:0]           pal_blue,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 out_valid
);

    localparam int XB     = $clog2(TILE_W);
    localparam int YB     = $clog2(TILE_H);
    localparam int X_SPAN = MAP_COLS * TILE_W;
    localparam int Y_SPAN = MAP_ROWS * TILE_H;

    typedef enum logic {WAIT_FRAME, RUN} state_t;

    state_t state_reg, state_next;
    logic   run;

    // Per-frame latched values
    logic [9:0]  sx_reg, sy_reg;
    logic [11:0] bg_reg;

    // World-space coordinates after the wrap subtract
    logic [10:0] wx_sum, wy_sum, wx, wy, col, row, map_next;

    // Pipeline stage registers; bg travels with each pixel so a pixel keeps
    // the background colour that was in force when it was sampled.
    logic          v1_reg, v2_reg, v3_reg;
    logic [XB-1:0] xlo1_reg, xlo2_reg;
    logic [YB-1:0] ylo1_reg, ylo2_reg;
    logic [11:0]   bg1_reg, bg2_reg, bg3_reg;
    logic [11:0]   rgb_reg;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_reg <= WAIT_FRAME;
        else       state_reg <= state_next;
    end

    // Next state: wait for the first frame_start, then run until reset
    always_comb begin
        state_next = state_reg;
        run        = 1'b0;
        case (state_reg)
            WAIT_FRAME: if (frame_start) state_next = RUN;
            RUN:        run = 1'b1;
            default:    state_next = WAIT_FRAME;
        endcase
    end

    // Latch scroll and background on frame_start; out-of-range scroll becomes 0
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sx_reg <= '0;
            sy_reg <= '0;
            bg_reg <= '0;
        end else if (frame_start) begin
            sx_reg <= ({1'b0, scroll_x} >= 11'(X_SPAN)) ? 10'd0 : scroll_x;
            sy_reg <= ({1'b0, scroll_y} >= 11'(Y_SPAN)) ? 10'd0 : scroll_y;
            bg_reg <= bg_rgb;
        end
    end

    // Scrolled coordinate with a single conditional wrap, then tile col/row
    always_comb begin
        wx_sum   = {1'b0, DrawX} + {1'b0, sx_reg};
        wy_sum   = {1'b0, DrawY} + {1'b0, sy_reg};
        wx       = (wx_sum >= 11'(X_SPAN)) ? wx_sum - 11'(X_SPAN) : wx_sum;
        wy       = (wy_sum >= 11'(Y_SPAN)) ? wy_sum - 11'(Y_SPAN) : wy_sum;
        col      = wx >> XB;
        row      = wy >> YB;
        map_next = row * 11'(MAP_COLS) + col;
    end

    // Stage 1: register map address and in-tile offsets (held while waiting)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            v1_reg   <= 1'b0;
            map_addr <= '0;
            xlo1_reg <= '0;
            ylo1_reg <= '0;
            bg1_reg  <= '0;
        end else begin
            v1_reg  <= pix_valid_in && run;
            bg1_reg <= bg_reg;
            if (run) begin
                map_addr <= map_next;
                xlo1_reg <= wx[XB-1:0];
                ylo1_reg <= wy[YB-1:0];
            end
        end
    end

    // Stages 2 and 3: carry offsets/valid/bg alongside the map and ROM reads
    always_ff @(posedge Clk) begin
        if (Reset) begin
            v2_reg   <= 1'b0;
            v3_reg   <= 1'b0;
            xlo2_reg <= '0;
            ylo2_reg <= '0;
            bg2_reg  <= '0;
            bg3_reg  <= '0;
        end else begin
            v2_reg   <= v1_reg;
            v3_reg   <= v2_reg;
            xlo2_reg <= xlo1_reg;
            ylo2_reg <= ylo1_reg;
            bg2_reg  <= bg1_reg;
            bg3_reg  <= bg2_reg;
        end
    end

    assign rom_addr  = {map_data, ylo2_reg, xlo2_reg};
    assign pal_index = rom_data;

    // Stage 4: choose background for transparent pixels, blank invalid ones
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rgb_reg   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v3_reg;
            if (!v3_reg)
                rgb_reg <= '0;
            else if (pal_index == PIX_IDX_W'(TRANSP_IDX))
                rgb_reg <= bg3_reg;
            else
                rgb_reg <= {pal_red, pal_green, pal_blue};
        end
    end

    assign red   = rgb_reg[11:8];
    assign green = rgb_reg[7:4];
    assign blue  = rgb_reg[3:0];

endmodule
